snake_seg_mem_arbiter: RTL
==========================

SNAKE_SEG_MEM_ARBITER -- requirements
Module: snake_seg_mem_arbiter

Interface
REQ-001 Parameters SHALL be: X_BITS, 6, segment X width; Y_BITS, 6, segment Y width; S_ADDR_W, 8, segment address width; GRID_W, 60, grid columns; GRID_H, 40, grid rows.
REQ-002 sys_clk  in  1  clock; all logic rising-edge.
REQ-003 sys_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 clr_start_in  in  1  single-cycle pulse requesting a memory clear.
REQ-005 clr_busy_out  out  1  high while clear sweep runs.
REQ-006 wr_req_in / wr_addr_in / wr_x_in / wr_y_in  in  1 / S_ADDR_W / X_BITS / Y_BITS  game-logic segment write request and payload.
REQ-007 wr_ack_out  out  1  write granted this cycle.
REQ-008 col_req_in / col_addr_in  in  1 / S_ADDR_W  collision-scan read request.
REQ-009 col_ack_out, col_rvalid_out  out  1 each  read grant; read data valid.
REQ-010 col_x_out / col_y_out / col_seg_valid_out  out  X_BITS / Y_BITS / 1  collision read data.
REQ-011 vga_req_in / vga_addr_in  in  1 / S_ADDR_W  renderer read request.
REQ-012 vga_ack_out, vga_rvalid_out, vga_x_out, vga_y_out, vga_seg_valid_out  out  1 / 1 / X_BITS / Y_BITS / 1  renderer grant and read data.
REQ-013 wr_err_out  out  1  sticky out-of-grid write flag; present only per REQ-031.

Function
REQ-014 Block SHALL own a single-port synchronous RAM of 2^S_ADDR_W words; each word holds {seg_valid, x, y}.
REQ-015 FSM states SHALL be IDLE and CLEAR; only one RAM access per cycle.
REQ-016 In IDLE, a granted write SHALL store {1, wr_x_in, wr_y_in} at wr_addr_in.
REQ-017 Grant SHALL be combinational and same-cycle: ack high in the cycle of the access, exactly one ack high at most per cycle.
REQ-018 Priority SHALL be: write over any read; between reads, round-robin using a 1-bit last-granted register updated on every read grant.
REQ-019 When only one read port requests (no write), that port SHALL be granted regardless of round-robin state.
REQ-020 Read data SHALL appear with the port's rvalid pulse exactly 1 cycle after its ack; data outputs hold until that port's next rvalid.
REQ-021 Requester SHALL hold req/addr stable until ack; a req held high after ack is a new request; back-to-back reads on one port sustain 1 per cycle when uncontested.
REQ-022 Denied requests SHALL receive no ack and no state change; writes may starve reads (game writes are sparse by design).
REQ-023 clr_start_in in IDLE SHALL enter CLEAR on the next cycle; same-cycle requests are arbitrated normally.
REQ-024 CLEAR SHALL write {0,0,0} to addresses 0..2^S_ADDR_W-1, one per cycle, then return to IDLE; duration exactly 2^S_ADDR_W cycles.
REQ-025 In CLEAR, all acks SHALL be 0; clr_start_in SHALL be ignored (no restart); clr_busy_out = 1.
REQ-026 A read granted in the last IDLE cycle SHALL still deliver its rvalid during the first CLEAR cycle.

Reset
REQ-027 Asserting sys_reset_n low SHALL force all outputs (acks, rvalids, data, clr_busy_out, wr_err_out) to 0 and round-robin to favour vga next.
REQ-028 On reset release the FSM SHALL enter CLEAR (clr_busy_out = 1 on first clock edge), so RAM content is defined after every reset, including mid-sweep resets, which restart the sweep at address 0.
REQ-029 Pending rvalid from before reset SHALL be discarded.

Configuration
REQ-030 Macro SEG_ARB_GRID_GUARD_EN SHALL select write range checking.
REQ-031 Defined: a granted write with wr_x_in >= GRID_W or wr_y_in >= GRID_H SHALL be acked, not stored, and set wr_err_out (cleared only by reset).
REQ-032 Not defined: all granted writes SHALL be stored unchanged and wr_err_out SHALL be tied 0.

Verification
REQ-033 After reset, wait 256 cycles; vga read addr 5 -> vga_rvalid_out 1 cycle after ack, vga_seg_valid_out = 0.
REQ-034 Write addr 3 = (x 12, y 7), then col read addr 3 -> col_x_out = 12, col_y_out = 7, col_seg_valid_out = 1.
REQ-035 wr, col, vga all requesting same cycle -> wr_ack_out only; next two cycles col and vga acked alternately starting with vga.
REQ-036 clr_start_in pulse with vga_req_in held -> vga_ack_out 0 and clr_busy_out 1 for 256 cycles, then vga acked.
REQ-037 With SEG_ARB_GRID_GUARD_EN: write addr 9 = (x 60, y 0) -> wr_ack_out 1, wr_err_out 1, read addr 9 returns seg_valid 0; without macro, read returns (60, 0, 1).
REQ-038 Reset asserted at cycle 100 of a sweep -> outputs 0 immediately; after release clr_busy_out stays high 256 cycles.

Source files
------------

// File: rtl/snake_seg_mem_arbiter.sv
// Segment RAM arbiter for the snake game: one write port, two read ports, clear sweep.
// Optional macro SEG_ARB_GRID_GUARD_EN rejects out-of-grid writes and raises wr_err_out.
module snake_seg_mem_arbiter #(
    parameter int X_BITS   = 6,
    parameter int Y_BITS   = 6,
    parameter int S_ADDR_W = 8,
    parameter int GRID_W   = 60,
    parameter int GRID_H   = 40
) (
    input  logic                sys_clk,
    input  logic                sys_reset_n,
    input  logic                clr_start_in,
    output logic                clr_busy_out,
    input  logic                wr_req_in,
    input  logic [S_ADDR_W-1:0] wr_addr_in,
    input  logic [X_BITS-1:0]   wr_x_in,
    input  logic [Y_BITS-1:0]   wr_y_in,
    output logic                wr_ack_out,
    output logic                wr_err_out,
    input  logic                col_req_in,
    input  logic [S_ADDR_W-1:0] col_addr_in,
    output logic                col_ack_out,
    output logic                col_rvalid_out,
    output logic [X_BITS-1:0]   col_x_out,
    output logic [Y_BITS-1:0]   col_y_out,
    output logic                col_seg_valid_out,
    input  logic                vga_req_in,
    input  logic [S_ADDR_W-1:0] vga_addr_in,
    output logic                vga_ack_out,
    output logic                vga_rvalid_out,
    output logic [X_BITS-1:0]   vga_x_out,
    output logic [Y_BITS-1:0]   vga_y_out,
    output logic                vga_seg_valid_out
);

    localparam int WORD_W = 1 + X_BITS + Y_BITS;
    localparam int DEPTH  = 1 << S_ADDR_W;
    localparam logic [X_BITS:0] GRID_W_L = (X_BITS+1)'(GRID_W);
    localparam logic [Y_BITS:0] GRID_H_L = (Y_BITS+1)'(GRID_H);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_nxt;
    logic                boot_pend;
    logic [S_ADDR_W-1:0] clr_addr;
    logic                last_vga;
    logic                wr_ok;

    logic                mem_we;
    logic [S_ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic [WORD_W-1:0]   rd_word_p1;
    logic                col_vld_p1, vga_vld_p1;
    logic [WORD_W-1:0]   col_hold, vga_hold;
    logic [WORD_W-1:0]   col_word, vga_word;

    function automatic logic in_grid(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
        return ({1'b0, x} < GRID_W_L) && ({1'b0, y} < GRID_H_L);
    endfunction

`ifdef SEG_ARB_GRID_GUARD_EN
    logic wr_err_q;

    assign wr_ok      = in_grid(wr_x_in, wr_y_in);
    assign wr_err_out = wr_err_q;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n)
            wr_err_q <= 1'b0;
        else if (wr_ack_out && !wr_ok)
            wr_err_q <= 1'b1;
    end
`else
    assign wr_ok      = 1'b1;
    assign wr_err_out = 1'b0;
`endif

    // boot_pend forces a sweep right after every reset so RAM content is always defined
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state     <= IDLE;
            boot_pend <= 1'b1;
            clr_addr  <= '0;
        end else begin
            state     <= state_nxt;
            boot_pend <= 1'b0;
            clr_addr  <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (boot_pend || clr_start_in) state_nxt = CLEAR;
            CLEAR:   if (&clr_addr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_ack_out  = 1'b0;
        col_ack_out = 1'b0;
        vga_ack_out = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = clr_addr;
        mem_wdata   = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (!boot_pend) begin
            if (wr_req_in) begin
                wr_ack_out = 1'b1;
                mem_we     = wr_ok;
                mem_addr   = wr_addr_in;
                mem_wdata  = {1'b1, wr_x_in, wr_y_in};
            end else if (vga_req_in && (!col_req_in || !last_vga)) begin
                vga_ack_out = 1'b1;
                mem_addr    = vga_addr_in;
            end else if (col_req_in) begin
                col_ack_out = 1'b1;
                mem_addr    = col_addr_in;
            end
        end
    end

    assign clr_busy_out = (state == CLEAR);

    // last_vga = 0 after reset so the renderer wins the first contested read
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n)
            last_vga <= 1'b0;
        else if (vga_ack_out)
            last_vga <= 1'b1;
        else if (col_ack_out)
            last_vga <= 1'b0;
    end

    // stage p0 -> p1: single-port RAM access
    always_ff @(posedge sys_clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        rd_word_p1 <= mem[mem_addr];
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            col_vld_p1 <= 1'b0;
            vga_vld_p1 <= 1'b0;
            col_hold   <= '0;
            vga_hold   <= '0;
        end else begin
            col_vld_p1 <= col_ack_out;
            vga_vld_p1 <= vga_ack_out;
            if (col_vld_p1) col_hold <= rd_word_p1;
            if (vga_vld_p1) vga_hold <= rd_word_p1;
        end
    end

    // stage p1 outputs: fresh RAM word on rvalid, otherwise the held word
    assign col_word = col_vld_p1 ? rd_word_p1 : col_hold;
    assign vga_word = vga_vld_p1 ? rd_word_p1 : vga_hold;

    assign col_rvalid_out = col_vld_p1;
    assign vga_rvalid_out = vga_vld_p1;
    assign {col_seg_valid_out, col_x_out, col_y_out} = col_word;
    assign {vga_seg_valid_out, vga_x_out, vga_y_out} = vga_word;

endmodule
